fifo_read_controller: RTL and testbench
=======================================

Name: fifo_read_controller

Overview:
Read-side controller for the structural 32x8 FIFO RAM. It tracks the read pointer against the write pointer supplied by the write side and fetches one row at a time by driving the RAM row-select lines with Write_Enable low. Each fetched word is captured into an output register and presented to the consumer with a valid/ready handshake. It also arbitrates RAM row-line ownership with the write controller; the writer has priority.

Parameters:
DATA_WIDTH, 8, width of a RAM word
ADDR_WIDTH, 5, row address bits
DEPTH, 32, number of rows; must equal 2**ADDR_WIDTH

Ports:
Clock  input  1  single clock, rising edge
Reset  input  1  asynchronous, active-high
Wr_Ptr  input  ADDR_WIDTH+1  write pointer from write controller; binary, MSB is the wrap bit
Wr_Req  input  1  write controller requests the RAM row lines
Wr_Grant  output  1  write controller may drive row lines and Write_Enable this cycle
Ram_Data  input  DATA_WIDTH  shared RAM output bit lines
Rd_Row_Select  output  DEPTH  one-hot row select for reads
Rd_Ptr  output  ADDR_WIDTH+1  read pointer, binary with wrap bit
Empty  output  1  Wr_Ptr == Rd_Ptr
Occupancy  output  ADDR_WIDTH+1  (Wr_Ptr - Rd_Ptr) mod 2**(ADDR_WIDTH+1), range 0..DEPTH
Out_Data  output  DATA_WIDTH  registered read data
Out_Valid  output  1  Out_Data holds an unconsumed word
Out_Ready  input  1  consumer accepts the word
Flush  input  1  synchronous discard of all stored words
Error  output  1  sticky; Occupancy exceeded DEPTH

Behaviour:
- Reset (async, any state): state=IDLE, Rd_Ptr=0, Rd_Row_Select=0, Out_Data=0, Out_Valid=0, Error=0. Reset during FETCH aborts the fetch; the pointer does not advance.
- States:
  - IDLE: Rd_Row_Select=0, Out_Valid=0.
  - FETCH: Rd_Row_Select = onehot(Rd_Ptr[ADDR_WIDTH-1:0]); lasts exactly 1 cycle.
  - HOLD: Out_Valid=1, Rd_Row_Select=0.
- can_fetch = !Empty & !Wr_Req.
- IDLE -> FETCH when can_fetch; otherwise stay in IDLE.
- FETCH -> HOLD always. On that edge: Out_Data <= Ram_Data; Rd_Ptr <= Rd_Ptr+1, wrapping 63->0 with the wrap bit toggling.
- HOLD with !Out_Ready: stay; Out_Data stable.
- HOLD with Out_Ready: go to FETCH if can_fetch, else IDLE. Evaluate with the already-updated Rd_Ptr.
- Latency: IDLE with a non-empty FIFO gives Out_Valid 2 cycles later.
- Throughput: 1 word per 2 cycles; Out_Valid is low during each FETCH.
- Rd_Row_Select is registered and glitch-free. Its register is loaded on the edge entering FETCH and cleared on the edge leaving it.
- Arbitration:
  - Wr_Grant = Wr_Req & (state != FETCH), combinational.
  - FETCH is never entered while Wr_Req is high, so read and write never overlap.
  - The reader may starve while Wr_Req stays high. This is bounded: the writer stops requesting when full.
- Empty and Occupancy are combinational from Wr_Ptr and Rd_Ptr. A word sitting in Out_Data has already left the RAM and is not counted.
- Error is set on any cycle where Occupancy > DEPTH and is cleared only by Reset.
- Flush (synchronous, highest priority after Reset): Rd_Ptr <= Wr_Ptr, state <= IDLE, Out_Valid <= 0, Rd_Row_Select <= 0. Out_Data keeps its value. Error is unchanged.
- Flush in the same cycle as the FETCH edge: no capture, no increment.

Decomposition:
- Shared package fifo_pkg holds:
  - state encoding constants (IDLE=2'b00, FETCH=2'b01, HOLD=2'b10);
  - DATA_WIDTH, ADDR_WIDTH and DEPTH defaults;
  - the pointer-width constant ADDR_WIDTH+1, shared with the write controller.
- One sub-module, row_decoder_5to32: combinational binary to one-hot decoder producing the select pattern that Rd_Row_Select registers. It is reusable by the write controller.

Test Plan:
- Reset, Wr_Ptr=0 -> Empty=1, Occupancy=0, Out_Valid=0, Rd_Row_Select=0, Wr_Grant follows Wr_Req.
- Wr_Ptr=1, RAM row0=8'hA5, Out_Ready=1 -> next cycle Rd_Row_Select=32'h1 for exactly 1 cycle; following cycle Out_Valid=1, Out_Data=8'hA5, Rd_Ptr=1, Empty=1.
- Wr_Ptr=3, Out_Ready=0 -> Out_Valid held with Out_Data stable for 10 cycles, Occupancy=2. Raise Out_Ready -> words 2 and 3 appear, each followed by a FETCH cycle.
- Rd_Ptr=6'd31, Wr_Ptr=6'd33 -> fetch row 31 (Rd_Row_Select=32'h8000_0000), then Rd_Ptr=6'd32; next fetch of row 0 gives Rd_Ptr=6'd33, Empty=1.
- Wr_Req held high with FIFO non-empty -> no FETCH, Wr_Grant=1. Wr_Req rising in FETCH -> Wr_Grant=0 that cycle, 1 the next.
- Flush asserted in HOLD with Wr_Ptr=20 -> next cycle Out_Valid=0, Rd_Ptr=20, Empty=1. Force Wr_Ptr-Rd_Ptr=33 -> Error=1 and stays set until Reset.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and state encoding for the 32x8 FIFO read/write controllers.
// The pointer width carries one extra wrap bit so that full and empty can be told apart.
package fifo_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned ADDR_WIDTH = 5;
    localparam int unsigned DEPTH      = 32;
    localparam int unsigned PTR_WIDTH  = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        HOLD  = 2'b10
    } rd_state_e;

endpackage

// File: rtl/row_decoder_5to32.sv
// Binary row address to one-hot row-select pattern for the FIFO RAM.
// Purely combinational; shared by the read and write controllers.
module row_decoder_5to32 #(
    parameter int unsigned ADDR_WIDTH = fifo_pkg::ADDR_WIDTH,
    parameter int unsigned DEPTH      = fifo_pkg::DEPTH
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic [DEPTH-1:0]      onehot_o
);

    always_comb begin
        onehot_o         = '0;
        onehot_o[addr_i] = 1'b1;
    end

endmodule

// File: rtl/fifo_read_controller.sv
// Read-side controller for the 32x8 FIFO RAM: fetches one row per FETCH cycle into a
// registered output with valid/ready handshake; the write controller has row-line priority.
module fifo_read_controller #(
    parameter int unsigned DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = fifo_pkg::ADDR_WIDTH,
    parameter int unsigned DEPTH      = fifo_pkg::DEPTH
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [ADDR_WIDTH:0]   Wr_Ptr,
    input  logic                  Wr_Req,
    output logic                  Wr_Grant,
    input  logic [DATA_WIDTH-1:0] Ram_Data,
    output logic [DEPTH-1:0]      Rd_Row_Select,
    output logic [ADDR_WIDTH:0]   Rd_Ptr,
    output logic                  Empty,
    output logic [ADDR_WIDTH:0]   Occupancy,
    output logic [DATA_WIDTH-1:0] Out_Data,
    output logic                  Out_Valid,
    input  logic                  Out_Ready,
    input  logic                  Flush,
    output logic                  Error
);

    import fifo_pkg::*;

    localparam logic [ADDR_WIDTH:0] PtrOne   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] DepthPtr = DEPTH[ADDR_WIDTH:0];

    rd_state_e             state_q, state_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0]      row_sel_q, row_sel_d;
    logic [DEPTH-1:0]      row_dec;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  error_q, error_d;
    logic                  empty;
    logic                  can_fetch;
    logic [ADDR_WIDTH:0]   occupancy;

    row_decoder_5to32 #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DEPTH     (DEPTH)
    ) u_row_dec (
        .addr_i  (rd_ptr_q[ADDR_WIDTH-1:0]),
        .onehot_o(row_dec)
    );

    assign empty     = (Wr_Ptr == rd_ptr_q);
    assign occupancy = Wr_Ptr - rd_ptr_q;
    // The writer owns the row lines whenever it asks, so a fetch only starts when it is idle.
    assign can_fetch = !empty && !Wr_Req;

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        row_sel_d   = row_sel_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        error_d     = error_q | (occupancy > DepthPtr);

        case (state_q)
            IDLE: begin
                if (can_fetch) begin
                    state_d   = FETCH;
                    row_sel_d = row_dec;
                end
            end
            FETCH: begin
                state_d     = HOLD;
                row_sel_d   = '0;
                out_data_d  = Ram_Data;
                rd_ptr_d    = rd_ptr_q + PtrOne;
                out_valid_d = 1'b1;
            end
            HOLD: begin
                if (Out_Ready) begin
                    out_valid_d = 1'b0;
                    if (can_fetch) begin
                        state_d   = FETCH;
                        row_sel_d = row_dec;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                row_sel_d   = '0;
                out_valid_d = 1'b0;
            end
        endcase

        // A flush on the FETCH edge also cancels the capture and the pointer increment.
        if (Flush) begin
            state_d     = IDLE;
            rd_ptr_d    = Wr_Ptr;
            row_sel_d   = '0;
            out_data_d  = out_data_q;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            rd_ptr_q    <= '0;
            row_sel_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            row_sel_q   <= row_sel_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            error_q     <= error_d;
        end
    end

    assign Wr_Grant      = Wr_Req && (state_q != FETCH);
    assign Rd_Row_Select = row_sel_q;
    assign Rd_Ptr        = rd_ptr_q;
    assign Empty         = empty;
    assign Occupancy     = occupancy;
    assign Out_Data      = out_data_q;
    assign Out_Valid     = out_valid_q;
    assign Error         = error_q;

endmodule

// File: tb/tb_fifo_read_controller.sv
// Directed bench for fifo_read_controller with a behavioural RAM driving the bit lines
// from the registered row select.
module tb_fifo_read_controller;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [5:0]  Wr_Ptr = '0;
    logic        Wr_Req = 1'b0;
    logic        Wr_Grant;
    logic [7:0]  Ram_Data;
    logic [31:0] Rd_Row_Select;
    logic [5:0]  Rd_Ptr;
    logic        Empty;
    logic [5:0]  Occupancy;
    logic [7:0]  Out_Data;
    logic        Out_Valid;
    logic        Out_Ready = 1'b0;
    logic        Flush = 1'b0;
    logic        Error;

    logic [7:0]  ram [32];
    int          n_vec = 0;
    int          n_err = 0;

    fifo_read_controller dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Wr_Ptr       (Wr_Ptr),
        .Wr_Req       (Wr_Req),
        .Wr_Grant     (Wr_Grant),
        .Ram_Data     (Ram_Data),
        .Rd_Row_Select(Rd_Row_Select),
        .Rd_Ptr       (Rd_Ptr),
        .Empty        (Empty),
        .Occupancy    (Occupancy),
        .Out_Data     (Out_Data),
        .Out_Valid    (Out_Valid),
        .Out_Ready    (Out_Ready),
        .Flush        (Flush),
        .Error        (Error)
    );

    always #5 Clock = ~Clock;

    // Bit lines are the wired-OR of every selected row.
    always_comb begin
        Ram_Data = '0;
        for (int i = 0; i < 32; i++) begin
            if (Rd_Row_Select[i]) Ram_Data = Ram_Data | ram[i];
        end
    end

    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ram[i] = 8'h5A;
        ram[0]  = 8'hA5;
        ram[1]  = 8'h11;
        ram[2]  = 8'h22;
        ram[3]  = 8'h33;
        ram[31] = 8'hF1;

        // Reset state
        #1 Reset = 1'b1;
        tick();
        tick();
        chk("rst_empty", Empty, 1);
        chk("rst_occ", Occupancy, 0);
        chk("rst_valid", Out_Valid, 0);
        chk("rst_row", Rd_Row_Select, 0);
        chk("rst_data", Out_Data, 0);
        chk("rst_rdptr", Rd_Ptr, 0);
        chk("rst_error", Error, 0);
        Wr_Req = 1'b1;
        #1 chk("rst_grant_hi", Wr_Grant, 1);
        Wr_Req = 1'b0;
        #1 chk("rst_grant_lo", Wr_Grant, 0);
        Reset = 1'b0;
        tick();

        // Single word: one FETCH cycle, then HOLD
        Wr_Ptr = 6'd1;
        Out_Ready = 1'b1;
        tick();
        chk("w0_row", Rd_Row_Select, 32'h1);
        chk("w0_fetch_valid", Out_Valid, 0);
        tick();
        chk("w0_row_clr", Rd_Row_Select, 0);
        chk("w0_valid", Out_Valid, 1);
        chk("w0_data", Out_Data, 8'hA5);
        chk("w0_rdptr", Rd_Ptr, 1);
        chk("w0_empty", Empty, 1);
        tick();
        chk("w0_idle_valid", Out_Valid, 0);

        // Back-pressure
        Out_Ready = 1'b0;
        Wr_Ptr = 6'd3;
        #1 chk("bp_occ2", Occupancy, 2);
        tick();
        chk("bp_row", Rd_Row_Select, 32'h2);
        tick();
        chk("bp_data", Out_Data, 8'h11);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold_valid", Out_Valid, 1);
            chk("bp_hold_data", Out_Data, 8'h11);
        end
        chk("bp_occ1", Occupancy, 1);
        Out_Ready = 1'b1;
        tick();
        chk("bp_fetch2_valid", Out_Valid, 0);
        chk("bp_fetch2_row", Rd_Row_Select, 32'h4);
        tick();
        chk("bp_w2_valid", Out_Valid, 1);
        chk("bp_w2_data", Out_Data, 8'h22);
        chk("bp_w2_rdptr", Rd_Ptr, 3);
        Wr_Ptr = 6'd5;
        tick();
        chk("bp_fetch3_row", Rd_Row_Select, 32'h8);
        Out_Ready = 1'b0;
        tick();
        chk("bp_w3_data", Out_Data, 8'h33);
        chk("bp_w3_rdptr", Rd_Ptr, 4);

        // Flush while holding a word
        Wr_Ptr = 6'd20;
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        chk("fl_valid", Out_Valid, 0);
        chk("fl_rdptr", Rd_Ptr, 20);
        chk("fl_empty", Empty, 1);
        chk("fl_data_kept", Out_Data, 8'h33);
        chk("fl_error", Error, 0);

        // Wrap across row 31 -> row 0
        Wr_Ptr = 6'd31;
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        chk("wr_rdptr31", Rd_Ptr, 31);
        Wr_Ptr = 6'd33;
        Out_Ready = 1'b1;
        #1 chk("wr_occ", Occupancy, 2);
        tick();
        chk("wr_row31", Rd_Row_Select, 32'h8000_0000);
        tick();
        chk("wr_data31", Out_Data, 8'hF1);
        chk("wr_rdptr32", Rd_Ptr, 32);
        chk("wr_not_empty", Empty, 0);
        tick();
        chk("wr_row0", Rd_Row_Select, 32'h1);
        tick();
        chk("wr_data0", Out_Data, 8'hA5);
        chk("wr_rdptr33", Rd_Ptr, 33);
        chk("wr_empty", Empty, 1);
        tick();
        chk("wr_idle_valid", Out_Valid, 0);

        // Writer priority
        Wr_Req = 1'b1;
        Wr_Ptr = 6'd35;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("arb_no_fetch", Rd_Row_Select, 0);
            chk("arb_grant", Wr_Grant, 1);
            chk("arb_rdptr", Rd_Ptr, 33);
        end
        Wr_Req = 1'b0;
        tick();
        chk("arb_fetch_row", Rd_Row_Select, 32'h2);
        Wr_Req = 1'b1;
        #1 chk("arb_grant_fetch", Wr_Grant, 0);
        tick();
        chk("arb_grant_after", Wr_Grant, 1);
        chk("arb_data", Out_Data, 8'h11);
        tick();
        chk("arb_idle_valid", Out_Valid, 0);
        chk("arb_idle_row", Rd_Row_Select, 0);

        // Flush on the FETCH edge: no capture, no increment
        Wr_Req = 1'b0;
        Out_Ready = 1'b0;
        tick();
        chk("ff_row", Rd_Row_Select, 32'h4);
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        chk("ff_data_kept", Out_Data, 8'h11);
        chk("ff_rdptr", Rd_Ptr, 35);
        chk("ff_valid", Out_Valid, 0);
        chk("ff_row_clr", Rd_Row_Select, 0);

        // Overflow error is sticky until Reset
        Wr_Req = 1'b1;
        Wr_Ptr = 6'd4;
        #1 chk("err_occ33", Occupancy, 33);
        chk("err_pre", Error, 0);
        tick();
        chk("err_set", Error, 1);
        Wr_Ptr = 6'd35;
        tick();
        tick();
        chk("err_sticky", Error, 1);
        chk("err_occ0", Occupancy, 0);
        Reset = 1'b1;
        #1 chk("err_rst_clr", Error, 0);
        chk("err_rst_rdptr", Rd_Ptr, 0);
        chk("err_rst_data", Out_Data, 0);
        tick();
        Reset = 1'b0;

        // Reset during FETCH aborts the fetch
        Wr_Req = 1'b0;
        Wr_Ptr = 6'd2;
        tick();
        chk("rf_row", Rd_Row_Select, 32'h1);
        Reset = 1'b1;
        #1 chk("rf_row_clr", Rd_Row_Select, 0);
        chk("rf_rdptr", Rd_Ptr, 0);
        tick();
        chk("rf_valid", Out_Valid, 0);
        chk("rf_rdptr_hold", Rd_Ptr, 0);
        Reset = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
